// File: rtl/uart_tx.sv
// uart_tx: parallel-in, serial-out UART transmitter.
//   Takes a W_IN-bit word on a valid/ready handshake and sends it as
//   NUM_WORDS = W_IN/BITS_PER_WORD serial frames, least-significant word
//   first. Each frame is: start (0), data bits LSB first, optional even
//   parity, stop (1). Every bit lasts CLOCKS_PER_PULSE clk cycles.
// Ports:
//   clk      in   clock, rising edge
//   rstn     in   asynchronous active-low reset
//   s_valid  in   upstream word valid
//   s_ready  out  high only while idle (registered)
//   s_data   in   W_IN-bit word, captured on handshake
//   tx       out  serial line, idle high (registered)
// Build option: define UART_TX_PARITY_EN to add an even-parity bit after
//   the data bits of every frame.
module uart_tx #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int W_IN             = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W_IN-1:0] s_data,
  output logic            tx
);
  localparam int NUM_WORDS = W_IN / BITS_PER_WORD;
  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam int BW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BITS_PER_WORD - 1);
  localparam logic [WW-1:0] W_LAST = WW'(NUM_WORDS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state;
  logic [CW-1:0]   clk_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [WW-1:0]   word_cnt;
  logic [W_IN-1:0] shreg;
`ifdef UART_TX_PARITY_EN
  logic            par;
`endif

  // shreg shifts right once per data bit, so after one word's bits have
  // gone out, shreg[0] already holds bit 0 of the next word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      s_ready  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (s_valid && s_ready) begin
            shreg   <= s_data;
            state   <= START;
            tx      <= 1'b0;
            s_ready <= 1'b0;
            clk_cnt <= '0;
          end
        end
        START: begin
          if (clk_cnt == C_LAST) begin
            clk_cnt <= '0;
            state   <= DATA;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
`ifdef UART_TX_PARITY_EN
            par     <= shreg[0];
`endif
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == C_LAST) begin
            clk_cnt <= '0;
            if (bit_cnt == B_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx      <= par;
`else
              state   <= STOP;
              tx      <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
`ifdef UART_TX_PARITY_EN
              par     <= par ^ shreg[0];
`endif
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (clk_cnt == C_LAST) begin
            clk_cnt <= '0;
            state   <= STOP;
            tx      <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (clk_cnt == C_LAST) begin
            clk_cnt <= '0;
            if (word_cnt == W_LAST) begin
              word_cnt <= '0;
              state    <= IDLE;
              s_ready  <= 1'b1;
            end else begin
              word_cnt <= word_cnt + 1'b1;
              state    <= START;
              tx       <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          s_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx at default
// parameters (4 clocks/bit, 8-bit words, 16-bit input).
module tb_uart_tx;
  localparam int CPP = 4;
  localparam int BPW = 8;
  localparam int WIN = 16;
  localparam int NW  = WIN / BPW;
`ifdef UART_TX_PARITY_EN
  localparam int FB = BPW + 3;
`else
  localparam int FB = BPW + 2;
`endif
  localparam int NCYC = NW * FB * CPP;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        tx;

  int checks = 0;
  int failures = 0;

  uart_tx #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(BPW), .W_IN(WIN)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .tx(tx)
  );

  always #5 clk = ~clk;

  // Expected line level for frame-bit index idx of word d.
  function automatic logic exp_bit(input logic [15:0] d, input int idx);
    int w, b;
    logic [7:0] wd;
    w  = idx / FB;
    b  = idx % FB;
    wd = d[w*BPW +: BPW];
    if (b == 0) return 1'b0;
    if (b <= BPW) return wd[b-1];
    if (b == BPW + 1 && FB == BPW + 3) return ^wd;
    return 1'b1;
  endfunction

  // Handshake at the next posedge once idle; keep=1 leaves s_valid high.
  task automatic handshake(input logic [15:0] d, input bit keep);
    int n = 0;
    @(negedge clk);
    while (!s_ready && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (!s_ready) begin
      failures++;
      $display("FAIL hs_wait: s_ready=%b required 1", s_ready);
    end
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clk);
    #1;
    if (!keep) s_valid = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset: tx=%b s_ready=%b required 1 1", tx, s_ready);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_a55a;
    logic [0:19] golden;
    int low = 0;
    golden = 20'b0010110101_0101001011;
    handshake(16'hA55A, 1'b0);
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (!s_ready) low++;
      checks++;
      if (tx !== exp_bit(16'hA55A, c / CPP)) begin
        failures++;
        $display("FAIL a55a_bit c=%0d: tx=%b required %b", c, tx, exp_bit(16'hA55A, c / CPP));
      end
`ifndef UART_TX_PARITY_EN
      checks++;
      if (tx !== golden[c / CPP]) begin
        failures++;
        $display("FAIL a55a_golden c=%0d: tx=%b required %b", c, tx, golden[c / CPP]);
      end
`endif
    end
    @(negedge clk);
    checks++;
    if (low != NCYC || s_ready !== 1'b1 || tx !== 1'b1) begin
      failures++;
      $display("FAIL a55a_ready: low=%0d required %0d, s_ready=%b tx=%b", low, NCYC, s_ready, tx);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    int low = 0;
    handshake(16'h0107, 1'b0);
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (!s_ready) low++;
      // parity bit of word0 and word1 are both 1
      if ((c / CPP) % FB == BPW + 1) begin
        checks++;
        if (tx !== 1'b1) begin
          failures++;
          $display("FAIL parity c=%0d: tx=%b required 1", c, tx);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (low != 88 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL parity_ready: low=%0d required 88 s_ready=%b", low, s_ready);
    end
  endtask
`endif

  task automatic test_busy_ignore;
    handshake(16'h1234, 1'b0);
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (c == 12) begin s_valid = 1'b1; s_data = 16'hFFFF; end
      if (c == 14) s_valid = 1'b0;
      checks++;
      if (tx !== exp_bit(16'h1234, c / CPP)) begin
        failures++;
        $display("FAIL busy_bit c=%0d: tx=%b required %b", c, tx, exp_bit(16'h1234, c / CPP));
      end
    end
    for (int c = 0; c < 2 * FB * CPP; c++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || s_ready !== 1'b1) begin
        failures++;
        $display("FAIL busy_idle c=%0d: tx=%b s_ready=%b required 1 1", c, tx, s_ready);
      end
    end
  endtask

  task automatic test_back_to_back;
    handshake(16'h00FF, 1'b1);
    s_data = 16'hFF00;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      checks++;
      if (tx !== exp_bit(16'h00FF, c / CPP) || s_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_first c=%0d: tx=%b s_ready=%b required %b 0", c, tx, s_ready, exp_bit(16'h00FF, c / CPP));
      end
    end
    // single idle cycle between frames
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gap: tx=%b s_ready=%b required 1 1", tx, s_ready);
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      checks++;
      if (tx !== exp_bit(16'hFF00, c / CPP) || s_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_second c=%0d: tx=%b s_ready=%b required %b 0", c, tx, s_ready, exp_bit(16'hFF00, c / CPP));
      end
    end
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_end: s_ready=%b required 1", s_ready);
    end
  endtask

  task automatic test_reset_mid_frame;
    handshake(16'h5555, 1'b0);
    repeat (10) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: tx=%b s_ready=%b required 1 1", tx, s_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    handshake(16'h5555, 1'b0);
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      checks++;
      if (tx !== exp_bit(16'h5555, c / CPP)) begin
        failures++;
        $display("FAIL post_reset c=%0d: tx=%b required %b", c, tx, exp_bit(16'h5555, c / CPP));
      end
    end
  endtask

  // Behavioural LSB-first receiver sampling mid-bit.
  task automatic test_loopback;
    logic [15:0] sent, got;
    int n;
    bit ok;
    for (int k = 0; k < 100; k++) begin
      sent = 16'($urandom);
      got  = '0;
      ok   = 1'b1;
      handshake(sent, 1'b0);
      for (int w = 0; w < NW; w++) begin
        n = 0;
        while (tx !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        if (tx !== 1'b0) ok = 1'b0;
        repeat (CPP / 2) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int b = 0; b < BPW; b++) begin
          repeat (CPP) @(negedge clk);
          got[w*BPW + b] = tx;
        end
        repeat ((FB - BPW - 1) * CPP) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
      end
      checks++;
      if (got !== sent || !ok) begin
        failures++;
        $display("FAIL loopback k=%0d: got=%h framing_ok=%0d required %h 1", k, got, ok, sent);
      end
    end
  endtask

  initial begin
    test_reset;
    test_frame_a55a;
`ifdef UART_TX_PARITY_EN
    test_parity;
`endif
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid_frame;
    test_loopback;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
